self_clean_ctrl: RTL and testbench
==================================

Name: self_clean_ctrl

Overview:
Parametrised self-clean controller for the range-hood design. It has its own 1 Hz tick prescaler and a configurable hold-to-arm time and clean duration. It supports pause/resume and abort, and presents the remaining time as MM:SS BCD for the seven-segment display path. It sits between the button debouncers/power FSM and the display/indicator logic.

Parameters:
TICK_CYCLES, 100_000_000, clk cycles per 1-second tick (>=2).
HOLD_SEC, 3, seconds start_clean must be held to arm (1..15).
CLEAN_SEC, 180, clean duration in seconds (1..5999).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
is_on  input  1  hood powered on (level)
start_clean  input  1  clean request (level, debounced)
pause_req  input  1  single-cycle pulse; toggles pause/resume
abort  input  1  level; cancels cleaning
arming  output  1  high in ARM
cleaning  output  1  high in CLEAN or PAUSE
paused  output  1  high in PAUSE
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse on cancelled clean
time_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones} of remaining

Behaviour:
- Clock and reset: rst is asynchronous, active-high; clk is the clock. All state is updated on the rising edge of clk.
- Reset values: state=IDLE, prescaler=0, hold_cnt=0, remaining=CLEAN_SEC. arming, cleaning, paused, done and aborted are all 0. time_bcd shows CLEAN_SEC (0x0300 for 180).
- Status outputs are Moore-decoded from the state register. done is high exactly for the single cycle the state is DONE. aborted is a registered one-cycle pulse, asserted in the cycle after the abort transition.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 while in ARM or CLEAN.
  - tick is asserted in the cycle where prescaler==TICK_CYCLES-1; the counter then wraps to 0.
  - The prescaler is frozen in PAUSE and cleared to 0 on every entry to ARM or CLEAN (including resume). The first second after entry or resume is therefore always a full second.
- remaining width is clog2(CLEAN_SEC+1).
- time_bcd is a combinational decode of remaining: minutes=remaining/60, seconds=remaining%60, each digit in 0..9.
- IDLE:
  - remaining held at CLEAN_SEC, hold_cnt held at 0.
  - is_on && start_clean -> ARM.
- ARM:
  - start_clean==0 or is_on==0 in any cycle -> IDLE. This has priority over tick; no aborted pulse is issued.
  - On tick: hold_cnt+1. When that tick makes hold_cnt==HOLD_SEC -> CLEAN.
  - ARM therefore lasts HOLD_SEC*TICK_CYCLES cycles.
- CLEAN:
  - Priority order: (abort || !is_on) > pause_req > tick.
  - abort or !is_on -> IDLE, aborted pulse.
  - pause_req -> PAUSE. A tick in the same cycle is discarded.
  - On tick: remaining-1. If remaining was 1 -> DONE with remaining=0.
- PAUSE:
  - remaining and prescaler are frozen.
  - abort or !is_on -> IDLE, aborted pulse (abort has priority over pause_req).
  - pause_req -> CLEAN.
- DONE: one cycle with time_bcd=0x0000, then -> IDLE. start_clean still held at this point does not re-arm until the cycle after IDLE is entered.
- pause_req outside CLEAN/PAUSE is ignored. start_clean in CLEAN/PAUSE is ignored.
- Asserting rst mid-operation returns everything to reset values immediately, with no done or aborted pulse.

Test Plan:
(Bench uses TICK_CYCLES=4, HOLD_SEC=3, CLEAN_SEC=5 unless noted.)
1. Full run: is_on=1, start_clean held -> arming for 12 cycles; cleaning for 20 cycles with time_bcd 0x0005, 0x0004 … 0x0001 each held 4 cycles; done high 1 cycle with 0x0000; then IDLE showing 0x0005.
2. Early release: start_clean dropped after 7 cycles in ARM -> IDLE next cycle, cleaning never 1, no aborted pulse.
3. Pause/resume: pause_req at remaining=3 -> paused=1 and time_bcd frozen at 0x0003 for 50 cycles. A second pause_req -> CLEAN; the next decrement occurs exactly 4 cycles later.
4. Abort and power loss: abort in CLEAN at 0x0002 -> aborted pulse 1 cycle, IDLE, 0x0005. Repeat with is_on=0 during PAUSE -> same result.
5. Simultaneous events: pause_req coincident with tick -> PAUSE, remaining unchanged. abort coincident with pause_req in PAUSE -> IDLE with aborted pulse.
6. Defaults and reset: CLEAN_SEC=180, TICK_CYCLES=4 -> time_bcd 0x0300, then 0x0259 after the first tick. rst asserted mid-CLEAN -> outputs cleared asynchronously with no done pulse.

Source files
------------

// File: rtl/self_clean_ctrl.sv
// Self-clean controller for the range hood: hold-to-arm, timed clean with pause/resume/abort,
// and an MM:SS BCD readout of the remaining clean time.
module self_clean_ctrl #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int HOLD_SEC    = 3,
  parameter int CLEAN_SEC   = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_on,
  input  logic        start_clean,
  input  logic        pause_req,
  input  logic        abort,
  output logic        arming,
  output logic        cleaning,
  output logic        paused,
  output logic        done,
  output logic        aborted,
  output logic [15:0] time_bcd
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int RW = $clog2(CLEAN_SEC + 1);

  typedef enum logic [2:0] {IDLE, ARM, CLEAN, PAUSE, DONE} state_t;

  state_t        state, state_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic [3:0]    hold_cnt, hold_cnt_next;
  logic [RW-1:0] remaining, remaining_next;
  logic          aborted_next;
  logic          tick;
  logic          kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      hold_cnt  <= '0;
      remaining <= RW'(CLEAN_SEC);
      aborted   <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      hold_cnt  <= hold_cnt_next;
      remaining <= remaining_next;
      aborted   <= aborted_next;
    end
  end

  assign tick = ((state == ARM) || (state == CLEAN)) &&
                (prescaler == PW'(TICK_CYCLES - 1));
  assign kill = abort || !is_on;

  // The prescaler is zeroed on every way into ARM or CLEAN so the first second is always whole.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    hold_cnt_next  = hold_cnt;
    remaining_next = remaining;
    aborted_next   = 1'b0;
    case (state)
      IDLE: begin
        prescaler_next = '0;
        hold_cnt_next  = '0;
        remaining_next = RW'(CLEAN_SEC);
        if (is_on && start_clean) state_next = ARM;
      end
      ARM: begin
        if (!start_clean || !is_on) begin
          state_next     = IDLE;
          prescaler_next = '0;
          hold_cnt_next  = '0;
        end else if (tick) begin
          prescaler_next = '0;
          if (hold_cnt + 4'd1 == 4'(HOLD_SEC)) begin
            state_next    = CLEAN;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt + 4'd1;
          end
        end else begin
          prescaler_next = prescaler + PW'(1);
        end
      end
      CLEAN: begin
        if (kill) begin
          state_next     = IDLE;
          prescaler_next = '0;
          remaining_next = RW'(CLEAN_SEC);
          aborted_next   = 1'b1;
        end else if (pause_req) begin
          state_next = PAUSE;
        end else if (tick) begin
          prescaler_next = '0;
          if (remaining == RW'(1)) begin
            state_next     = DONE;
            remaining_next = '0;
          end else begin
            remaining_next = remaining - RW'(1);
          end
        end else begin
          prescaler_next = prescaler + PW'(1);
        end
      end
      PAUSE: begin
        if (kill) begin
          state_next     = IDLE;
          prescaler_next = '0;
          remaining_next = RW'(CLEAN_SEC);
          aborted_next   = 1'b1;
        end else if (pause_req) begin
          state_next     = CLEAN;
          prescaler_next = '0;
        end
      end
      DONE: begin
        state_next     = IDLE;
        prescaler_next = '0;
        remaining_next = RW'(CLEAN_SEC);
      end
      default: begin
        state_next     = IDLE;
        prescaler_next = '0;
        hold_cnt_next  = '0;
        remaining_next = RW'(CLEAN_SEC);
      end
    endcase
  end

  assign arming   = (state == ARM);
  assign cleaning = (state == CLEAN) || (state == PAUSE);
  assign paused   = (state == PAUSE);
  assign done     = (state == DONE);

  // Remaining seconds split into minutes and seconds, then each into decimal digits.
  logic [31:0] rem_full, mins, secs;
  always_comb begin
    rem_full = 32'(remaining);
    mins     = rem_full / 32'd60;
    secs     = rem_full - mins * 32'd60;
    time_bcd = {4'(mins / 32'd10), 4'(mins % 32'd10),
                4'(secs / 32'd10), 4'(secs % 32'd10)};
  end

endmodule

// File: tb/tb_self_clean_ctrl.sv
// Directed bench for self_clean_ctrl: a vector table for the main flows plus hand sequences
// for pause timing, the 180 s default readout and asynchronous reset.
module tb_self_clean_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic is_on, start_clean, pause_req, abort;
  logic arming, cleaning, paused, done, aborted;
  logic [15:0] time_bcd;
  logic arming2, cleaning2, paused2, done2, aborted2;
  logic [15:0] time_bcd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  self_clean_ctrl #(.TICK_CYCLES(4), .HOLD_SEC(3), .CLEAN_SEC(5)) dut (
    .clk(clk), .rst(rst), .is_on(is_on), .start_clean(start_clean),
    .pause_req(pause_req), .abort(abort), .arming(arming), .cleaning(cleaning),
    .paused(paused), .done(done), .aborted(aborted), .time_bcd(time_bcd)
  );

  self_clean_ctrl #(.TICK_CYCLES(4), .HOLD_SEC(3), .CLEAN_SEC(180)) dut_long (
    .clk(clk), .rst(rst), .is_on(is_on), .start_clean(start_clean),
    .pause_req(pause_req), .abort(abort), .arming(arming2), .cleaning(cleaning2),
    .paused(paused2), .done(done2), .aborted(aborted2), .time_bcd(time_bcd2)
  );

  // Flag order: {arming, cleaning, paused, done, aborted}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_ARM  = 5'b10000;
  localparam logic [4:0] F_CLN  = 5'b01000;
  localparam logic [4:0] F_PAU  = 5'b01100;
  localparam logic [4:0] F_DONE = 5'b00010;
  localparam logic [4:0] F_ABT  = 5'b00001;

  typedef struct {
    logic        on;
    logic        start;
    logic        pause;
    logic        abrt;
    int          cycles;
    logic [4:0]  flags;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic on, input logic start, input logic pause,
                              input logic abrt, input int cycles,
                              input logic [4:0] flags, input logic [15:0] bcd);
    vec_t v;
    v.on = on; v.start = start; v.pause = pause; v.abrt = abrt;
    v.cycles = cycles; v.flags = flags; v.bcd = bcd;
    vecs.push_back(v);
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic on, input logic start, input logic pause,
                                input logic abrt);
    is_on       = on;
    start_clean = start;
    pause_req   = pause;
    abort       = abrt;
  endtask

  task automatic check_output(input string name, input logic [4:0] exp_flags,
                              input logic [15:0] exp_bcd);
    logic [4:0] act;
    act = {arming, cleaning, paused, done, aborted};
    checks++;
    if (act !== exp_flags || time_bcd !== exp_bcd) begin
      errors++;
      $display("[TB] FAIL %s: flags=%b bcd=%h, expected flags=%b bcd=%h",
               name, act, time_bcd, exp_flags, exp_bcd);
    end
  endtask

  task automatic check_long(input string name, input logic [4:0] exp_flags,
                            input logic [15:0] exp_bcd);
    logic [4:0] act;
    act = {arming2, cleaning2, paused2, done2, aborted2};
    checks++;
    if (act !== exp_flags || time_bcd2 !== exp_bcd) begin
      errors++;
      $display("[TB] FAIL %s: flags=%b bcd=%h, expected flags=%b bcd=%h",
               name, act, time_bcd2, exp_flags, exp_bcd);
    end
  endtask

  initial begin
    // Full run
    add(1,1,0,0, 1, F_ARM,  16'h0005);
    add(1,1,0,0,10, F_ARM,  16'h0005);
    add(1,1,0,0, 1, F_ARM,  16'h0005);
    add(1,1,0,0, 1, F_CLN,  16'h0005);
    add(1,1,0,0, 3, F_CLN,  16'h0005);
    add(1,1,0,0, 1, F_CLN,  16'h0004);
    add(1,1,0,0, 3, F_CLN,  16'h0004);
    add(1,1,0,0, 1, F_CLN,  16'h0003);
    add(1,1,0,0, 4, F_CLN,  16'h0002);
    add(1,1,0,0, 4, F_CLN,  16'h0001);
    add(1,1,0,0, 3, F_CLN,  16'h0001);
    add(1,0,0,0, 1, F_DONE, 16'h0000);
    add(1,0,0,0, 1, F_IDLE, 16'h0005);
    // Early release of start_clean
    add(1,1,0,0, 7, F_ARM,  16'h0005);
    add(1,0,0,0, 1, F_IDLE, 16'h0005);
    add(1,0,0,0, 1, F_IDLE, 16'h0005);
    // Abort while cleaning at 0:02
    add(1,1,0,0,12, F_ARM,  16'h0005);
    add(1,1,0,0,13, F_CLN,  16'h0002);
    add(1,0,0,1, 1, F_ABT,  16'h0005);
    add(1,0,0,0, 1, F_IDLE, 16'h0005);
    // Power loss while paused
    add(1,1,0,0,12, F_ARM,  16'h0005);
    add(1,1,0,0, 2, F_CLN,  16'h0005);
    add(1,1,1,0, 1, F_PAU,  16'h0005);
    add(1,1,0,0, 5, F_PAU,  16'h0005);
    add(0,0,0,0, 1, F_ABT,  16'h0005);
    add(1,0,0,0, 1, F_IDLE, 16'h0005);
    // Pause on the tick cycle, then abort together with pause_req
    add(1,1,0,0,12, F_ARM,  16'h0005);
    add(1,1,0,0, 4, F_CLN,  16'h0005);
    add(1,1,1,0, 1, F_PAU,  16'h0005);
    add(1,1,0,0, 3, F_PAU,  16'h0005);
    add(1,0,1,1, 1, F_ABT,  16'h0005);
    add(1,0,0,0, 1, F_IDLE, 16'h0005);
    // pause_req in IDLE is ignored
    add(1,0,1,0, 1, F_IDLE, 16'h0005);
    add(1,0,0,0, 1, F_IDLE, 16'h0005);

    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    check_output("reset_state", F_IDLE, 16'h0005);
    check_long("reset_state_180", F_IDLE, 16'h0300);
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    check_output("idle_after_reset", F_IDLE, 16'h0005);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].on, vecs[i].start, vecs[i].pause, vecs[i].abrt);
      step(vecs[i].cycles);
      check_output($sformatf("vec%0d", i), vecs[i].flags, vecs[i].bcd);
    end

    // Pause at 0:03 for 50 cycles, resume, next decrement a full second later
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step(12);
    check_output("p_arm_end", F_ARM, 16'h0005);
    step(10);
    check_output("p_before_pause", F_CLN, 16'h0003);
    pause_req = 1'b1;
    step(1);
    pause_req = 1'b0;
    check_output("p_enter", F_PAU, 16'h0003);
    for (int k = 0; k < 50; k++) begin
      step(1);
      check_output($sformatf("p_hold%0d", k), F_PAU, 16'h0003);
    end
    pause_req = 1'b1;
    step(1);
    pause_req = 1'b0;
    check_output("p_resume", F_CLN, 16'h0003);
    for (int k = 1; k < 4; k++) begin
      step(1);
      check_output($sformatf("p_after%0d", k), F_CLN, 16'h0003);
    end
    step(1);
    check_output("p_decrement", F_CLN, 16'h0002);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    check_output("p_abort", F_ABT, 16'h0005);
    abort = 1'b0;
    step(1);
    check_output("p_idle", F_IDLE, 16'h0005);

    // 180 s readout and asynchronous reset in the middle of a clean
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check_long("d_reset", F_IDLE, 16'h0300);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step(13);
    check_long("d_clean_start", F_CLN, 16'h0300);
    step(3);
    check_long("d_before_tick", F_CLN, 16'h0300);
    step(1);
    check_long("d_first_tick", F_CLN, 16'h0259);
    check_output("r_mid_clean", F_CLN, 16'h0004);
    #3;
    start_clean = 1'b0;
    rst = 1'b1;
    #1;
    check_output("r_async", F_IDLE, 16'h0005);
    check_long("r_async_180", F_IDLE, 16'h0300);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_output($sformatf("r_held%0d", k), F_IDLE, 16'h0005);
    end
    rst = 1'b0;
    step(1);
    check_output("r_released", F_IDLE, 16'h0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
